uart_tx_arbiter: RTL and testbench

- Shares one uart_send transmitter between NUM_REQ byte producers (loopback path, status reporter, debug dumper, etc.).
- Each requester offers bytes on a valid/ready handshake. The block picks one requester per byte by round-robin and drives uart_send's uart_en/uart_din.
- It sequences each byte against uart_tx_busy, and supports locked multi-byte frames so that frames from different requesters never interleave.

---
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one uart_send transmitter between NUM_REQ byte producers. One
// requester is picked per byte by round-robin; its byte is handed to
// uart_send with a one-cycle send_en pulse and then tracked against
// tx_busy. A requester can lock the grant across several bytes so that
// frames from different producers never interleave on the wire.
//
// Ports:
//   sys_clk      system clock
//   sys_rst      asynchronous, active-high reset
//   req_valid    per-requester byte valid
//   req_data     byte of requester i on bits [8i+7:8i]
//   req_lock     hold the grant for this requester's next byte
//   req_ready    one-hot accept strobe (combinational)
//   tx_busy      busy flag from uart_send
//   send_en      one-cycle start pulse to uart_send
//   send_data    byte being sent (held until the next transfer)
//   grant_id     requester whose byte is in flight (held until the next transfer)
//   locked       a locked frame is in progress
//   timeout_err  one-cycle pulse when tx_busy never rose after send_en
//
// Handshake: a byte moves on a rising sys_clk edge where req_valid[i] and
// req_ready[i] are both high. req_ready is only ever raised for the current
// winner, only in IDLE with tx_busy low, and only while that requester is
// valid. A requester may drop req_valid at any time without penalty.
//
// The FSM state register is state_q, named so checkers can bind to it.

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_busy,
    output logic                 send_en,
    output logic [7:0]           send_data,
    output logic [ID_W-1:0]      grant_id,
    output logic                 locked,
    output logic                 timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    logic               found;
    logic [ID_W-1:0]    win_id;
    logic [7:0]         win_data;
    logic               win_lock;
    logic [NUM_REQ-1:0] win_onehot;
    logic               accept;

    // Winner selection. grant_id doubles as the round-robin pointer: it is
    // always the id of the last accepted requester, so scanning from
    // grant_id+1 gives round-robin order. While locked, only the holder is
    // eligible; it sits at distance NUM_REQ in the scan, so the same loop
    // covers both cases.
    always_comb begin
        found      = 1'b0;
        win_id     = grant_id;
        win_data   = 8'h00;
        win_lock   = 1'b0;
        win_onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i]
                    && (i == (int'(grant_id) + k) % NUM_REQ)
                    && (!locked || i == int'(grant_id))) begin
                    found         = 1'b1;
                    win_id        = ID_W'(i);
                    win_data      = req_data[8*i +: 8];
                    win_lock      = req_lock[i];
                    win_onehot[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        send_en     = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                // While uart_send is still busy nothing is offered.
                if (!tx_busy) begin
                    req_ready = win_onehot;
                    if (found) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                send_en = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // uart_send never started: drop the byte and move on.
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            send_data <= 8'h00;
            grant_id  <= ID_W'(NUM_REQ - 1);
            locked    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                send_data <= win_data;
                grant_id  <= win_id;
                locked    <= win_lock;
            end else if (timeout_err) begin
                // A dead transmitter must not leave the other requesters
                // stalled behind a lock that will never be released.
                locked <= 1'b0;
            end

            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_BUSY && !tx_busy && !timeout_err) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of whole-byte
// transactions, hand-written multi-cycle corner cases (lock stall, busy
// timeout, busy while idle, reset mid-frame) and a randomized run checked
// against a transaction-level reference model with an expected-byte queue.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int BUSY_TIMEOUT = 16;

    logic                 sys_clk   = 1'b0;
    logic                 sys_rst   = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_lock  = '0;
    logic                 tx_busy   = 1'b0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 send_en;
    logic [7:0]           send_data;
    logic [ID_W-1:0]      grant_id;
    logic                 locked;
    logic                 timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard of bytes expected on send_en: {grant_id, byte}.
    logic [ID_W+7:0] exp_q[$];

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_data;
        logic        exp_locked;
    } vec_t;

    vec_t vecs[11];

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_lock(req_lock),
        .req_ready(req_ready),
        .tx_busy(tx_busy),
        .send_en(send_en),
        .send_data(send_data),
        .grant_id(grant_id),
        .locked(locked),
        .timeout_err(timeout_err)
    );

    // ---------------- driver tasks ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Move to the drive slot: just after the next rising edge.
    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    // From a drive slot with requests applied: wait (bounded) for an accept,
    // check its one-hot strobe, and return at the drive slot of the send_en cycle.
    task automatic wait_accept(input int exp_id, input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk);
            if (req_ready != '0) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s accept: req_ready stayed 0, expected %0h within 40 cycles", nm, 1 << exp_id);
        end else begin
            check({nm, " ready"}, 32'(req_ready), 32'(1 << exp_id));
            next_cycle();
        end
    endtask

    // From the send_en drive slot: check the issued byte, then play uart_send
    // (busy high for busy_hi cycles, starting one cycle after send_en).
    // Returns at the drive slot of the first cycle with tx_busy low again.
    task automatic issue(input int exp_id, input logic [7:0] exp_data,
                         input logic exp_locked, input int busy_hi, input string nm);
        @(negedge sys_clk);
        check({nm, " send_en"}, 32'(send_en), 32'd1);
        check({nm, " send_data"}, 32'(send_data), 32'(exp_data));
        check({nm, " grant_id"}, 32'(grant_id), 32'(exp_id));
        check({nm, " locked"}, 32'(locked), 32'(exp_locked));
        check({nm, " ready at issue"}, 32'(req_ready), 32'd0);
        next_cycle();
        tx_busy = 1'b1;
        for (int k = 0; k < busy_hi; k++) begin
            @(negedge sys_clk);
            check({nm, " ready while busy"}, 32'(req_ready), 32'd0);
            check({nm, " send_en while busy"}, 32'(send_en), 32'd0);
            next_cycle();
        end
        tx_busy = 1'b0;
    endtask

    function automatic int pick(input logic [3:0] v, input int ptr, input bit lk);
        int w;
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w < 0 && i == (ptr + k) % NUM_REQ && v[i] && (!lk || i == ptr)) begin
                    w = i;
                end
            end
        end
        return w;
    endfunction

    // Transaction-level reference: after an accept at cycle t the byte is
    // started at t+1; with busy rising d cycles after that and lasting h
    // cycles, the next accept is possible at t+2+d+h; if busy never rises,
    // the error pulse is at t+1+BUSY_TIMEOUT and accepts resume one later.
    task automatic run_random(input int n_cycles);
        int              m_ptr, m_avail, send_cyc, to_cyc, lock_clr;
        int              busy_on, busy_off, w, d, h;
        logic            m_lock;
        logic [ID_W-1:0] m_id;
        logic [7:0]      m_data;
        logic [3:0]      exp_ready;
        logic [ID_W+7:0] got;
        m_ptr = NUM_REQ - 1;
        m_id = ID_W'(NUM_REQ - 1);
        m_data = 8'h00;
        m_lock = 1'b0;
        m_avail = 0;
        send_cyc = -1;
        to_cyc = -1;
        lock_clr = -1;
        busy_on = -1;
        busy_off = -1;
        for (int c = 0; c < n_cycles; c++) begin
            if (c < n_cycles - 30) begin
                req_valid = 4'($urandom_range(0, 15));
                req_data  = $urandom();
                req_lock  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            end else begin
                req_valid = '0;
                req_lock  = '0;
            end
            tx_busy = (c >= busy_on) && (c < busy_off);
            if (c == lock_clr) m_lock = 1'b0;
            w = -1;
            if (c >= m_avail && !tx_busy) w = pick(req_valid, m_ptr, m_lock);
            exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;

            @(negedge sys_clk);
            check("rnd ready", 32'(req_ready), 32'(exp_ready));
            check("rnd send_en", 32'(send_en), 32'(c == send_cyc));
            check("rnd timeout_err", 32'(timeout_err), 32'(c == to_cyc));
            check("rnd locked", 32'(locked), 32'(m_lock));
            check("rnd held id/byte", 32'({grant_id, send_data}), 32'({m_id, m_data}));
            if (send_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rnd scoreboard: send_en with byte %0h, expected no send", send_data);
                end else begin
                    got = exp_q.pop_front();
                    check("rnd sent id/byte", 32'({grant_id, send_data}), 32'(got));
                end
            end

            if (w >= 0) begin
                m_ptr  = w;
                m_id   = ID_W'(w);
                m_data = 8'(req_data >> (8 * w));
                m_lock = |(req_lock & (4'b0001 << w));
                exp_q.push_back({m_id, m_data});
                send_cyc = c + 1;
                if ($urandom_range(0, 7) == 0) begin
                    to_cyc   = c + 1 + BUSY_TIMEOUT;
                    lock_clr = c + 2 + BUSY_TIMEOUT;
                    m_avail  = c + 2 + BUSY_TIMEOUT;
                    busy_on  = -1;
                    busy_off = -1;
                end else begin
                    d = $urandom_range(1, 3);
                    h = $urandom_range(1, 4);
                    busy_on  = c + 1 + d;
                    busy_off = busy_on + h;
                    m_avail  = c + 2 + d + h;
                end
            end
            next_cycle();
        end
        check("rnd scoreboard drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0]  = '{4'b1111, 4'b0000, 32'h13121110, 0, 8'h10, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 32'h13121110, 1, 8'h11, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 32'h13121110, 2, 8'h12, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 32'h13121110, 3, 8'h13, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 32'h13121110, 0, 8'h10, 1'b0};
        vecs[5]  = '{4'b0100, 4'b0100, 32'h00310000, 2, 8'h31, 1'b1};
        vecs[6]  = '{4'b0111, 4'b0100, 32'h0032A1A0, 2, 8'h32, 1'b1};
        vecs[7]  = '{4'b0111, 4'b0000, 32'h0033A1A0, 2, 8'h33, 1'b0};
        vecs[8]  = '{4'b1011, 4'b0000, 32'h43004140, 3, 8'h43, 1'b0};
        vecs[9]  = '{4'b0011, 4'b0000, 32'h43004140, 0, 8'h40, 1'b0};
        vecs[10] = '{4'b0001, 4'b0000, 32'h000000A5, 0, 8'hA5, 1'b0};

        // Reset values.
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("reset send_en", 32'(send_en), 32'd0);
        check("reset send_data", 32'(send_data), 32'h00);
        check("reset grant_id", 32'(grant_id), 32'(NUM_REQ - 1));
        check("reset locked", 32'(locked), 32'd0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        check("reset ready", 32'(req_ready), 32'd0);
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;

        // Round-robin, locked frame, single byte.
        for (int i = 0; i < 11; i++) begin
            req_valid = vecs[i].valid;
            req_lock  = vecs[i].lock;
            req_data  = vecs[i].data;
            wait_accept(vecs[i].exp_id, $sformatf("row%0d", i));
            issue(vecs[i].exp_id, vecs[i].exp_data, vecs[i].exp_locked, 2, $sformatf("row%0d", i));
        end

        // Lock holder idle: everyone else stays stalled.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        req_data  = 32'h00007700;
        wait_accept(1, "stall lock");
        issue(1, 8'h77, 1'b1, 2, "stall lock");
        req_valid = 4'b1101;
        req_lock  = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            check("stall ready", 32'(req_ready), 32'd0);
            check("stall locked", 32'(locked), 32'd1);
            next_cycle();
        end
        req_valid = 4'b1111;
        req_data  = 32'h33227811;
        wait_accept(1, "stall release");
        issue(1, 8'h78, 1'b0, 2, "stall release");

        // tx_busy never rises: error pulse BUSY_TIMEOUT cycles after send_en.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        req_data  = 32'h00005A00;
        wait_accept(1, "timeout");
        @(negedge sys_clk);
        check("timeout send_en", 32'(send_en), 32'd1);
        check("timeout send_data", 32'(send_data), 32'h5A);
        check("timeout locked", 32'(locked), 32'd1);
        for (int k = 1; k <= BUSY_TIMEOUT; k++) begin
            next_cycle();
            @(negedge sys_clk);
            check($sformatf("timeout_err at +%0d", k), 32'(timeout_err), 32'(k == BUSY_TIMEOUT));
            check("timeout no resend", 32'(send_en), 32'd0);
            check("timeout ready", 32'(req_ready), 32'd0);
        end
        next_cycle();
        req_data = 32'h00005B00;
        req_lock = 4'b0000;
        @(negedge sys_clk);
        check("after timeout locked", 32'(locked), 32'd0);
        check("after timeout ready", 32'(req_ready), 32'b0010);
        check("after timeout err", 32'(timeout_err), 32'd0);
        next_cycle();
        issue(1, 8'h5B, 1'b0, 2, "after timeout");

        // tx_busy high while idle blocks accepts until it drops.
        req_valid = 4'b0000;
        next_cycle();
        next_cycle();
        req_valid = 4'b0001;
        req_data  = 32'h000000B0;
        tx_busy   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            check("busy idle ready", 32'(req_ready), 32'd0);
            next_cycle();
        end
        tx_busy = 1'b0;
        @(negedge sys_clk);
        check("busy drop ready", 32'(req_ready), 32'b0001);
        next_cycle();
        issue(0, 8'hB0, 1'b0, 2, "busy drop");

        // Reset asserted in WAIT_DONE of a locked frame.
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        req_data  = 32'h00C20000;
        wait_accept(2, "midrst");
        @(negedge sys_clk);
        check("midrst send_en", 32'(send_en), 32'd1);
        next_cycle();
        tx_busy = 1'b1;
        next_cycle();
        check("midrst locked before", 32'(locked), 32'd1);
        #1;
        sys_rst = 1'b1;
        #1;
        check("midrst send_en", 32'(send_en), 32'd0);
        check("midrst locked", 32'(locked), 32'd0);
        check("midrst grant_id", 32'(grant_id), 32'(NUM_REQ - 1));
        check("midrst send_data", 32'(send_data), 32'h00);
        next_cycle();
        tx_busy   = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        #1;
        sys_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            check("post reset send_en", 32'(send_en), 32'd0);
            next_cycle();
        end
        req_valid = 4'b0111;
        req_data  = 32'h00C2D1D0;
        @(negedge sys_clk);
        check("post reset ready", 32'(req_ready), 32'b0001);
        next_cycle();
        issue(0, 8'hD0, 1'b0, 2, "post reset");

        // Randomized run from a fresh reset.
        req_valid = '0;
        req_lock  = '0;
        sys_rst   = 1'b1;
        #2;
        sys_rst = 1'b0;
        next_cycle();
        run_random(700);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
